div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative RV32M divider that executes DIV, DIVU, REM and REMU.
- Sits in the execute stage, alongside the ALU.
- Its result feeds the data-1 input of the writeback result 2:1 selector; the decoder drives that selector high on done.
- Uses a restoring radix-2 algorithm, one quotient bit per cycle; the pipeline stalls while busy is high.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CNT_W, $clog2(WIDTH): width of the iteration counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous active-high reset.
- start  input  1  request a divide; accepted only in IDLE.
- flush  input  1  synchronous abort, from branch/trap redirect.
- op  input  2  div_op_t; equals funct3[1:0] of the M-extension divide group.
- dividend  input  WIDTH  rs1 value, sampled on accept.
- divisor  input  WIDTH  rs2 value, sampled on accept.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  WIDTH  quotient or remainder; holds its value until the next completion.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high (reset).
- While reset is asserted: state=IDLE, counter=0, internal registers=0, busy=0, done=0, result=0. All are forced immediately, including mid-operation.

Op encoding:
- DIV=00, DIVU=01, REM=10, REMU=11.
- Signed ops: DIV, REM. Quotient ops: DIV, DIVU.

States: IDLE, CALC, FIX, DONE.

IDLE:
- Accept condition: start=1 and flush=0. Operands and op are latched on accept.
- Special case, divisor==0: go directly to DONE. The result register loads all-ones for DIV/DIVU, or the dividend for REM/REMU.
- Special case, signed overflow (DIV/REM, dividend==0x8000_0000, divisor==all-ones): go to DONE. The result register loads 0x8000_0000 for DIV, or 0 for REM.
- Otherwise go to CALC:
  - Latch absolute values for signed ops, raw values for unsigned ops.
  - Record neg_q = sign(dividend) XOR sign(divisor), for signed ops only.
  - Record neg_r = sign(dividend), for signed ops only.
  - Clear the partial remainder; set counter=WIDTH-1.

CALC:
- Each cycle: shift {rem, quo} left by one, bringing in the quotient MSB.
- Trial subtract rem-divisor, computed at WIDTH+1 bits. If the result is non-negative, keep the difference and set the quotient LSB to 1.
- The counter decrements each cycle. The step with counter==0 is the last one; the next state is FIX.
- Exactly WIDTH CALC cycles.

FIX:
- The result register loads the quotient or remainder, two's-complement negated per neg_q or neg_r.
- Next state: DONE.

DONE:
- done=1 for exactly this cycle.
- Next state: IDLE. start is not accepted while in DONE.

Latency (start high in cycle 0):
- Normal: done in cycle WIDTH+2, i.e. cycle 34 at WIDTH=32. busy is high in cycles 1 through WIDTH+2.
- Special cases: done in cycle 1.

Other rules:
- A start while busy is ignored; no queuing.
- flush in any non-IDLE state: next state IDLE, done never pulses, result is unchanged.
- flush in DONE: done still shows this cycle, because it is already registered.
- flush and start together in IDLE: flush wins and nothing is accepted.
- All subtraction is at WIDTH+1 bits; no overflow is possible. Negation wraps modulo 2^WIDTH.

Decomposition:
- Package div_pkg holds:
  - typedef enum logic [1:0] div_op_t with values DIV, DIVU, REM, REMU.
  - typedef enum div_state_t with values IDLE, CALC, FIX, DONE.
  - Helper functions is_signed(op) and is_rem(op).
- Sub-module div_step (combinational): inputs rem, quo, divisor; outputs next rem and next quo for one restoring iteration. It keeps the FSM file focused on control.

Test Plan:
1. DIVU 100/7, start in cycle 0 -> busy=1 in cycles 1–34; done=1 only in cycle 34 with result=14. With REMU instead, result=2.
2. DIV 0xFFFF_FFF9 (-7) / 2 -> result=0xFFFF_FFFD (-3). REM with the same operands -> 0xFFFF_FFFF (-1). DIV 7 / 0xFFFF_FFFE (-2) -> 0xFFFF_FFFD.
3. Divide by zero: DIV 5/0 -> done in cycle 1, result=0xFFFF_FFFF. REMU 5/0 -> result=5 in cycle 1.
4. Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF -> result=0x8000_0000 in cycle 1. REM with the same operands -> result=0.
5. Flush and restart: start DIVU 100/7, flush in cycle 10 -> busy=0 from cycle 11, done never pulses, result unchanged. Start in cycle 12 (DIVU 9/3) -> done in cycle 46, result=3. A start pulse in cycle 20 of that operation is ignored.
6. Reset mid-operation: assert reset asynchronously in cycle 15 of a DIV -> busy, done and result are 0 before the next clk edge. After release, a DIVU 1/1 completes normally with result=1.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and op decode helpers for the iterative divider
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  function automatic logic is_signed(div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem(div_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring radix-2 iteration on the {rem, quo} pair
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor on entry, so the kept value always fits back into WIDTH bits
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH]};
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  import div_pkg::*;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  div_op_t          op_q, op_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  div_op_t          op_in;
  logic             a_neg;
  logic             b_neg;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  assign op_in = div_op_t'(op);
  assign a_neg = is_signed(op_in) && dividend[WIDTH-1];
  assign b_neg = is_signed(op_in) && divisor[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    op_d      = op_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d = op_in;
          if (divisor == '0) begin
            result_d = is_rem(op_in) ? dividend : '1;
            state_d  = DONE;
          end else if (is_signed(op_in) && dividend == MIN_NEG && divisor == '1) begin
            result_d = is_rem(op_in) ? '0 : MIN_NEG;
            state_d  = DONE;
          end else begin
            quo_d     = a_neg ? -dividend : dividend;
            dvs_d     = b_neg ? -divisor : divisor;
            quo_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            rem_d     = '0;
            cnt_d     = CNT_W'(WIDTH - 1);
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (is_rem(op_q)) begin
          result_d = rem_neg_q ? -rem_q : rem_q;
        end else begin
          result_d = quo_neg_q ? -quo_q : quo_q;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect abandons the operation; the previous result stays visible
    if (flush && state_q != IDLE) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      op_q      <= DIV;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      op_q      <= op_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
